uart_transmitter: RTL and testbench

Serial transmit half of the UART. Accepts a byte over a single-cycle write strobe and drives it onto `TxD` as an 11-bit frame: start (0), 8 data bits LSB first, even parity, stop (1). Contains its own baud controller, so its frames are bit-compatible with `uart_receiver` at the same `baud_select`. Sits between the host/control logic and the serial pin, and is the loopback source for receiver tests.

---
 rtl/uart_transmitter.sv | 191 +++++++++++++++++++
 tb/tb_uart_transmitter.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_transmitter.sv
// UART transmit half: 8 data bits LSB first, even parity, one stop bit, with its own baud divider.
// Optional `UART_TX_HOLD_EN adds a one-byte holding register for back-to-back frames.
module uart_transmitter #(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] Tx_DATA,
  input  logic [2:0] baud_select,
  input  logic       Tx_WR,
  input  logic       Tx_EN,
  output logic       TxD,
  output logic       Tx_BUSY,
  output logic [2:0] tx_state
);

  // Handshake: a write is taken on a rising edge where Tx_WR & Tx_EN are high and
  // Tx_BUSY is low; Tx_BUSY is registered, so a write seen while it is high is dropped.

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  // Divisor table below is fixed for a 50 MHz clock.
  if (CLK_HZ != 50_000_000) begin : g_clk_hz_unsupported
  end

  logic [2:0]  state;
  logic [7:0]  shift;
  logic        parity_q;
  logic [2:0]  sel_q;
  logic [13:0] baud_cnt;
  logic [3:0]  tick_cnt;
  logic [2:0]  bit_idx;
  logic [13:0] divisor;
  logic        tick;
  logic        bit_done;
  logic        frame_end;
  logic        start_frame;
  logic [7:0]  start_data;
  logic [2:0]  start_sel;

  assign tx_state = state;

  always_comb begin
    divisor = 14'd27;
    case (sel_q)
      3'b000: divisor = 14'd10417;
      3'b001: divisor = 14'd2604;
      3'b010: divisor = 14'd651;
      3'b011: divisor = 14'd326;
      3'b100: divisor = 14'd163;
      3'b101: divisor = 14'd81;
      3'b110: divisor = 14'd54;
      default: divisor = 14'd27;
    endcase
  end

  assign tick      = (baud_cnt == divisor - 14'd1);
  assign bit_done  = tick && (tick_cnt == 4'hF);
  assign frame_end = (state == S_STOP) && bit_done;

`ifdef UART_TX_HOLD_EN
  logic [7:0] hold_data;
  logic [2:0] hold_sel;
  logic       hold_full;
  logic       wr_ok;
  logic       hold_load;
  logic       hold_clear;

  assign wr_ok = Tx_WR & Tx_EN;

  // At the end of a frame a pending byte starts immediately and the slot can refill in the same edge.
  always_comb begin
    start_frame = 1'b0;
    start_data  = Tx_DATA;
    start_sel   = baud_select;
    hold_load   = 1'b0;
    hold_clear  = 1'b0;
    if (state == S_IDLE) begin
      start_frame = wr_ok;
    end else if (frame_end) begin
      if (hold_full) begin
        start_frame = 1'b1;
        start_data  = hold_data;
        start_sel   = hold_sel;
        hold_load   = wr_ok;
        hold_clear  = ~wr_ok;
      end else begin
        start_frame = wr_ok;
      end
    end else begin
      hold_load = wr_ok & ~hold_full;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_full <= 1'b0;
      hold_data <= 8'h00;
      hold_sel  <= 3'b000;
      Tx_BUSY   <= 1'b0;
    end else if (hold_load) begin
      hold_full <= 1'b1;
      hold_data <= Tx_DATA;
      hold_sel  <= baud_select;
      Tx_BUSY   <= 1'b1;
    end else if (hold_clear) begin
      hold_full <= 1'b0;
      Tx_BUSY   <= 1'b0;
    end
  end
`else
  always_comb begin
    start_frame = Tx_WR & Tx_EN & ~Tx_BUSY;
    start_data  = Tx_DATA;
    start_sel   = baud_select;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      Tx_BUSY <= 1'b0;
    end else if (start_frame) begin
      Tx_BUSY <= 1'b1;
    end else if (frame_end) begin
      Tx_BUSY <= 1'b0;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      TxD      <= 1'b1;
      shift    <= 8'h00;
      parity_q <= 1'b0;
      sel_q    <= 3'b000;
      baud_cnt <= 14'd0;
      tick_cnt <= 4'd0;
      bit_idx  <= 3'd0;
    end else if (start_frame) begin
      // Counters restart here so a frame never inherits phase from idle time.
      state    <= S_START;
      TxD      <= 1'b0;
      shift    <= start_data;
      parity_q <= ^start_data;
      sel_q    <= start_sel;
      baud_cnt <= 14'd0;
      tick_cnt <= 4'd0;
      bit_idx  <= 3'd0;
    end else if (state != S_IDLE) begin
      if (bit_done) begin
        baud_cnt <= 14'd0;
        tick_cnt <= 4'd0;
        case (state)
          S_START: begin
            state   <= S_DATA;
            TxD     <= shift[0];
            bit_idx <= 3'd0;
          end
          S_DATA: begin
            shift <= shift >> 1;
            if (bit_idx == 3'd7) begin
              state <= S_PARITY;
              TxD   <= parity_q;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              TxD     <= shift[1];
            end
          end
          S_PARITY: begin
            state <= S_STOP;
            TxD   <= 1'b1;
          end
          default: begin
            state <= S_IDLE;
            TxD   <= 1'b1;
          end
        endcase
      end else if (tick) begin
        baud_cnt <= 14'd0;
        tick_cnt <= tick_cnt + 4'd1;
      end else begin
        baud_cnt <= baud_cnt + 14'd1;
      end
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Self-checking bench for uart_transmitter: random bytes checked bit-by-bit against a frame model.
// Also covers the UART_TX_HOLD_EN build when that macro is defined.
module tb_uart_transmitter;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] Tx_DATA;
  logic [2:0] baud_select;
  logic       Tx_WR;
  logic       Tx_EN;
  logic       TxD;
  logic       Tx_BUSY;
  logic [2:0] tx_state;

  int vectors = 0;
  int errors  = 0;
  logic [7:0] exp_q[$];

`ifdef UART_TX_HOLD_EN
  localparam bit BUSY_DURING_FRAME = 1'b0;
`else
  localparam bit BUSY_DURING_FRAME = 1'b1;
`endif

  uart_transmitter dut (
    .clk         (clk),
    .reset       (reset),
    .Tx_DATA     (Tx_DATA),
    .baud_select (baud_select),
    .Tx_WR       (Tx_WR),
    .Tx_EN       (Tx_EN),
    .TxD         (TxD),
    .Tx_BUSY     (Tx_BUSY),
    .tx_state    (tx_state)
  );

  // 50 MHz
  always #10 clk = ~clk;

  function automatic int bit_period(input logic [2:0] sel);
    int n;
    case (sel)
      3'd0: n = 10417;
      3'd1: n = 2604;
      3'd2: n = 651;
      3'd3: n = 326;
      3'd4: n = 163;
      3'd5: n = 81;
      3'd6: n = 54;
      default: n = 27;
    endcase
    return 16 * n;
  endfunction

  // Frame bit j: 0 start, 1..8 data LSB first, 9 even parity, 10 stop.
  function automatic logic frame_bit(input logic [7:0] d, input int j);
    int ones;
    if (j == 0) return 1'b0;
    if (j <= 8) return ((int'(d) >> (j - 1)) % 2) == 1;
    if (j == 9) begin
      ones = 0;
      for (int i = 0; i < 8; i++) ones += (int'(d) >> i) % 2;
      return (ones % 2) == 1;
    end
    return 1'b1;
  endfunction

  task automatic start_write(input logic [7:0] d, input logic [2:0] sel);
    Tx_DATA     = d;
    baud_select = sel;
    Tx_EN       = 1'b1;
    Tx_WR       = 1'b1;
    exp_q.push_back(d);
    @(posedge clk);
    @(negedge clk);
  endtask

  // Entered at the negedge just after the accept edge; leaves at the negedge after the frame-end edge.
  task automatic check_frame(input logic [2:0] sel, input int wr_hold, input bit scribble,
                             input logic [7:0] mid_data, input bit chk_busy, input bit chk_end,
                             input int inj_t, output logic busy_seen, input string name);
    logic [7:0] d;
    int   n;
    int   t;
    bit   bad;
    bit   busy_bad;
    logic got;
    logic busy_got;
    d = exp_q.pop_front();
    n = bit_period(sel);
    t = 0;
    busy_bad  = 1'b0;
    busy_got  = 1'b1;
    busy_seen = 1'bx;
    for (int j = 0; j < 11; j++) begin
      bad = 1'b0;
      got = frame_bit(d, j);
      for (int c = 0; c < n; c++) begin
        if (!bad && TxD !== frame_bit(d, j)) begin bad = 1'b1; got = TxD; end
        if (chk_busy && !busy_bad && Tx_BUSY !== 1'b1) begin busy_bad = 1'b1; busy_got = Tx_BUSY; end
        if (t == wr_hold - 1) Tx_WR = 1'b0;
        if (scribble) begin
          if (t == 5) begin
            Tx_DATA = mid_data;
            baud_select = 3'($urandom_range(0, 7));
`ifndef UART_TX_HOLD_EN
            Tx_WR = 1'b1;
`endif
          end
          if (t == 9) Tx_EN = 1'b0;
          if (t == 12) begin Tx_WR = 1'b0; Tx_EN = 1'b1; end
        end
        if (inj_t >= 0) begin
          if (t == inj_t) begin Tx_DATA = 8'hCC; baud_select = sel; Tx_WR = 1'b1; end
          if (t == inj_t + 1) begin busy_seen = Tx_BUSY; Tx_DATA = 8'hAA; end
          if (t == inj_t + 2) Tx_WR = 1'b0;
        end
        t++;
        @(negedge clk);
      end
      vectors++;
      if (bad) begin
        errors++;
        $display("FAIL %s bit%0d data=%02h: TxD=%b expected %b", name, j, d, got, frame_bit(d, j));
      end
    end
    if (chk_busy) begin
      vectors++;
      if (busy_bad) begin
        errors++;
        $display("FAIL %s busy_in_frame: Tx_BUSY=%b expected 1", name, busy_got);
      end
    end
    if (chk_end) begin
      vectors++;
      if (TxD !== 1'b1 || Tx_BUSY !== 1'b0) begin
        errors++;
        $display("FAIL %s frame_end: TxD=%b Tx_BUSY=%b expected TxD=1 Tx_BUSY=0", name, TxD, Tx_BUSY);
      end
    end
  endtask

  task automatic send(input logic [7:0] d, input logic [2:0] sel, input int wr_hold,
                      input bit scribble, input logic [7:0] mid_data, input string name);
    logic dummy;
    start_write(d, sel);
    check_frame(sel, wr_hold, scribble, mid_data, BUSY_DURING_FRAME, 1'b1, -1, dummy, name);
  endtask

  task automatic check_idle(input int cycles, input string name);
    bit   bad;
    logic tx_got;
    logic busy_got;
    bad = 1'b0;
    tx_got = 1'b1;
    busy_got = 1'b0;
    for (int c = 0; c < cycles; c++) begin
      if (!bad && (TxD !== 1'b1 || Tx_BUSY !== 1'b0)) begin bad = 1'b1; tx_got = TxD; busy_got = Tx_BUSY; end
      @(negedge clk);
    end
    vectors++;
    if (bad) begin
      errors++;
      $display("FAIL %s: TxD=%b Tx_BUSY=%b expected TxD=1 Tx_BUSY=0", name, tx_got, busy_got);
    end
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    Tx_WR = 1'b0;
    Tx_EN = 1'b1;
    Tx_DATA = 8'h00;
    baud_select = 3'b111;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    vectors++;
    if (TxD !== 1'b1) begin errors++; $display("FAIL reset_txd: TxD=%b expected 1", TxD); end
    vectors++;
    if (Tx_BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy: Tx_BUSY=%b expected 0", Tx_BUSY); end
    check_idle(10, "reset_idle");
  endtask

  task automatic test_basic();
    send(8'h55, 3'b111, 1, 1'b0, 8'h00, "basic_55");
    send(8'h89, 3'b111, 1, 1'b0, 8'h00, "parity_89");
    send(8'hCC, 3'b111, 1, 1'b0, 8'h00, "parity_cc");
  endtask

  task automatic test_ignored_writes();
`ifndef UART_TX_HOLD_EN
    send(8'h3C, 3'b111, 3, 1'b0, 8'h00, "held_wr");
    check_idle(40, "held_wr_single_frame");
    send(8'h0F, 3'b111, 1, 1'b1, 8'hAA, "midframe_aa");
`endif
    Tx_EN = 1'b0;
    Tx_WR = 1'b1;
    Tx_DATA = 8'h12;
    check_idle(40, "enable_off");
    Tx_WR = 1'b0;
    Tx_EN = 1'b1;
  endtask

  task automatic test_random();
    for (int i = 0; i < 3; i++)
      send(8'($urandom_range(0, 255)), 3'b111, 1, 1'b1, 8'($urandom_range(0, 255)), "random_111");
    send(8'($urandom_range(0, 255)), 3'b110, 1, 1'b1, 8'($urandom_range(0, 255)), "random_110");
  endtask

  // Only the first bit boundary at slower rates fits the run budget; each attempt ends in reset.
  task automatic test_slow_rates();
    logic [2:0] sels[4];
    int   n;
    int   win;
    bit   bad;
    logic [7:0] d;
    sels = '{3'd4, 3'd3, 3'd2, 3'd0};
    foreach (sels[s]) begin
      d = 8'($urandom_range(0, 255)) | 8'h01;
      start_write(d, sels[s]);
      void'(exp_q.pop_front());
      Tx_WR = 1'b0;
      baud_select = ~sels[s];
      n = bit_period(sels[s]);
      win = (n > 5000) ? 4000 : n;
      bad = 1'b0;
      for (int c = 0; c < win; c++) begin
        if (!bad && TxD !== 1'b0) bad = 1'b1;
        @(negedge clk);
      end
      vectors++;
      if (bad) begin errors++; $display("FAIL start_hold sel=%0d: TxD left 0 early, expected 0 for %0d cycles", sels[s], win); end
      if (win == n) begin
        vectors++;
        if (TxD !== 1'b1) begin errors++; $display("FAIL data0_edge sel=%0d: TxD=%b expected 1", sels[s], TxD); end
      end
      pulse_reset();
    end
    check_idle(5, "slow_rates_reset");
  endtask

  task automatic test_reset_midframe();
    int n;
    n = bit_period(3'b111);
    start_write(8'($urandom_range(0, 255)), 3'b111);
    void'(exp_q.pop_front());
    Tx_WR = 1'b0;
    repeat (4 * n + n / 2) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    vectors++;
    if (TxD !== 1'b1 || Tx_BUSY !== 1'b0) begin
      errors++;
      $display("FAIL reset_midframe: TxD=%b Tx_BUSY=%b expected TxD=1 Tx_BUSY=0", TxD, Tx_BUSY);
    end
    reset = 1'b0;
    check_idle(5, "reset_midframe_idle");
    send(8'h55, 3'b111, 1, 1'b0, 8'h00, "after_reset_55");
  endtask

`ifdef UART_TX_HOLD_EN
  task automatic test_back_to_back();
    logic busy_seen;
    logic dummy;
    start_write(8'h55, 3'b111);
    exp_q.push_back(8'hCC);
    check_frame(3'b111, 1, 1'b0, 8'h00, 1'b0, 1'b0, 100, busy_seen, "hold_first_55");
    vectors++;
    if (busy_seen !== 1'b1) begin errors++; $display("FAIL hold_busy: Tx_BUSY=%b expected 1", busy_seen); end
    check_frame(3'b111, 0, 1'b0, 8'h00, 1'b0, 1'b1, -1, dummy, "hold_second_cc");
    check_idle(40, "hold_third_ignored");
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_ignored_writes();
    test_random();
    test_slow_rates();
    test_reset_midframe();
`ifdef UART_TX_HOLD_EN
    test_back_to_back();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
